// File: rtl/div_issue_ctrl_pkg.sv
// Shared types and constants for the M-extension divider issue controller.
package div_issue_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] INT_MIN_W  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES_W = '1;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_WB    = 2'b11
  } div_ctrl_state_t;

endpackage

// File: rtl/div_result_fixup.sv
// Applies the RISC-V defined results for divide-by-zero and signed overflow
// on top of the raw divider output.
module div_result_fixup
  import div_issue_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  div_op_t          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] result_i,
  input  logic             dbz_i,
  input  logic             ovf_i,
  output logic [WIDTH-1:0] fixed_c_o
);

  // Narrow the XLEN constants down to WIDTH (valid for WIDTH <= XLEN).
  localparam logic [WIDTH-1:0] INT_MIN  = WIDTH'(INT_MIN_W >> (XLEN - WIDTH));
  localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(ALL_ONES_W);

  // Divide-by-zero outranks overflow; unsigned ops never overflow.
  always_comb begin
    fixed_c_o = result_i;
    if (dbz_i) begin
      fixed_c_o = (op_i inside {OP_DIV, OP_DIVU}) ? ALL_ONES : a_i;
    end else if (ovf_i) begin
      if (op_i == OP_DIV) begin
        fixed_c_o = INT_MIN;
      end else if (op_i == OP_REM) begin
        fixed_c_o = '0;
      end
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Requester-side controller for the multi-cycle integer divider: issues one
// op, tracks its rd for RAW hazards, fixes up the result and hands it to WB.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = XLEN,
  parameter int unsigned RD_W    = 5,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [RD_W-1:0]  req_rd,
  input  logic [RD_W-1:0]  dep_rs1,
  input  logic [RD_W-1:0]  dep_rs2,
  output logic             hazard,
  input  logic             flush,
  output logic             busy,
  output logic             div_start,
  output logic [1:0]       div_op,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  output logic [RD_W-1:0]  div_rd,
  output logic             div_clear,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_result,
  input  logic             div_dbz,
  input  logic             div_ovf,
  output logic             wb_valid,
  output logic [RD_W-1:0]  wb_rd,
  output logic [WIDTH-1:0] wb_data,
  input  logic             wb_ready,
  output logic             timeout_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  div_ctrl_state_t  state_q, state_d;
  div_op_t          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [RD_W-1:0]  rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;
  logic             clear_q, clear_d;
  logic             wb_valid_q, wb_valid_d;
  logic [RD_W-1:0]  wb_rd_q, wb_rd_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic             tmo_q, tmo_d;
  logic [WIDTH-1:0] fixed_c;

  div_result_fixup #(
    .WIDTH (WIDTH)
  ) u_fixup (
    .op_i      (op_q),
    .a_i       (a_q),
    .result_i  (div_result),
    .dbz_i     (div_dbz),
    .ovf_i     (div_ovf),
    .fixed_c_o (fixed_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    start_d    = 1'b0;
    clear_d    = 1'b0;
    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    tmo_d      = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && !flush) begin
          op_d    = div_op_t'(req_op);
          a_d     = req_a;
          b_d     = req_b;
          rd_d    = req_rd;
          start_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (flush) begin
          clear_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          clear_d = 1'b1;
          state_d = ST_IDLE;
        end else if (div_done) begin
          wb_data_d = fixed_c;
          wb_rd_d   = rd_q;
          // x0 destinations complete silently without a writeback slot.
          if (rd_q != '0) begin
            wb_valid_d = 1'b1;
            state_d    = ST_WB;
          end else begin
            state_d    = ST_IDLE;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          clear_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WB: begin
        if (wb_ready) begin
          wb_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_DIV;
      a_q        <= '0;
      b_q        <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      start_q    <= 1'b0;
      clear_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      start_q    <= start_d;
      clear_q    <= clear_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      tmo_q      <= tmo_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign hazard      = (state_q != ST_IDLE) && (rd_q != '0) &&
                       ((dep_rs1 == rd_q) || (dep_rs2 == rd_q));
  assign div_start   = start_q;
  assign div_clear   = clear_q;
  assign div_op      = op_q;
  assign div_a       = a_q;
  assign div_b       = b_q;
  assign div_rd      = rd_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign timeout_err = tmo_q;

endmodule
